// File: rtl/gene_stream_compress.sv
// ASCII nucleotide stream packer: folds CHARS_PER_BEAT ASCII bases per beat
// into 2-bit codes, emits OUT_BASES-base words, and tracks line-length and
// invalid-character errors.
module gene_stream_compress #(
  parameter int CHARS_PER_BEAT = 4,
  parameter int OUT_BASES      = 16,
  parameter int LINE_LEN       = 100
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [8*CHARS_PER_BEAT-1:0]            in_data,
  input  logic                                   in_last,
  input  logic [$clog2(CHARS_PER_BEAT+1)-1:0]    in_nchars,
  input  logic                                   clr_err,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [2*OUT_BASES-1:0]                 out_data,
  output logic [$clog2(OUT_BASES+1)-1:0]         out_count,
  output logic                                   out_last,
  output logic                                   err_invalid,
  output logic                                   err_len,
  output logic [15:0]                            invalid_cnt
);

  localparam int BW = 2 * CHARS_PER_BEAT;
  localparam int OW = 2 * OUT_BASES;
  localparam int CW = $clog2(OUT_BASES + 1);
  localparam int NW = $clog2(CHARS_PER_BEAT + 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t          state, state_next;
  logic [OW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            last_r;
  logic [15:0]     line_cnt;

  logic [NW-1:0]   nvalid;
  logic [BW-1:0]   beat_bits;
  logic [NW-1:0]   beat_inv;
  logic [OW-1:0]   placed;
  logic [CW-1:0]   new_cnt;
  logic [15:0]     line_total;
  logic            accept;

  // 2-bit code of one ASCII base; anything outside ACGT/acgt packs as 00.
  function automatic logic [1:0] enc_base(input logic [7:0] ch);
    case (ch)
      8'h43, 8'h63: enc_base = 2'b01;
      8'h47, 8'h67: enc_base = 2'b10;
      8'h54, 8'h74: enc_base = 2'b11;
      default:      enc_base = 2'b00;
    endcase
  endfunction

  function automatic logic is_acgt(input logic [7:0] ch);
    case (ch)
      8'h41, 8'h61, 8'h43, 8'h63, 8'h47, 8'h67, 8'h54, 8'h74: is_acgt = 1'b1;
      default: is_acgt = 1'b0;
    endcase
  endfunction

  // Invalid-character count add that pins at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [NW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {{(17-NW){1'b0}}, b};
    sat_add = s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign accept      = in_valid & in_ready;
  assign out_data    = acc;
  assign out_count   = cnt;
  assign out_last    = last_r;

  // Decode the incoming beat: valid base count, packed codes, invalid tally.
  always_comb begin
    nvalid    = NW'(CHARS_PER_BEAT);
    beat_bits = '0;
    beat_inv  = '0;
    if (in_last && in_nchars != '0 && in_nchars < NW'(CHARS_PER_BEAT))
      nvalid = in_nchars;
    for (int i = 0; i < CHARS_PER_BEAT; i++) begin
      if (NW'(i) < nvalid) begin
        beat_bits[BW-1-2*i -: 2] = enc_base(in_data[8*(CHARS_PER_BEAT-i)-1 -: 8]);
        if (!is_acgt(in_data[8*(CHARS_PER_BEAT-i)-1 -: 8]))
          beat_inv = beat_inv + NW'(1);
      end
    end
    placed     = (OW'(beat_bits) << (OW - BW)) >> {cnt, 1'b0};
    new_cnt    = cnt + CW'(nvalid);
    line_total = line_cnt + 16'(nvalid);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || new_cnt == CW'(OUT_BASES)))
          state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Accumulator: append accepted beats, hold while emitting, clear on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      last_r <= 1'b0;
    end else if (accept) begin
      acc    <= acc | placed;
      cnt    <= new_cnt;
      last_r <= in_last;
    end else if (state == EMIT && out_ready) begin
      acc    <= '0;
      cnt    <= '0;
      last_r <= 1'b0;
    end
  end

  // Line length tracking; restarts after every line-closing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      line_cnt <= '0;
    else if (accept)
      line_cnt <= in_last ? 16'd0 : line_total;
  end

  // Sticky error flags and invalid counter; a clear overrides same-cycle events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_invalid <= 1'b0;
      err_len     <= 1'b0;
      invalid_cnt <= '0;
    end else if (clr_err) begin
      err_invalid <= 1'b0;
      err_len     <= 1'b0;
      invalid_cnt <= '0;
    end else if (accept) begin
      if (beat_inv != '0) err_invalid <= 1'b1;
      if (in_last && line_total != 16'(LINE_LEN)) err_len <= 1'b1;
      invalid_cnt <= sat_add(invalid_cnt, beat_inv);
    end
  end

endmodule

// File: doc/gene_stream_compress.md
GENE_STREAM_COMPRESS -- requirements
Module: gene_stream_compress

Interface
REQ-001 Parameter CHARS_PER_BEAT, default 4: ASCII bases accepted per input beat.
REQ-002 Parameter OUT_BASES, default 16: bases per output word; SHALL be an integer multiple of CHARS_PER_BEAT.
REQ-003 Parameter LINE_LEN, default 100: expected bases per line, used for the length check.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 in_data  input  8*CHARS_PER_BEAT  ASCII bases; first base in the most-significant byte.
REQ-009 in_last  input  1  beat is the final beat of a line.
REQ-010 in_nchars  input  $clog2(CHARS_PER_BEAT+1)  valid bases in the beat, MSB-aligned; used only when in_last=1.
REQ-011 clr_err  input  1  synchronous clear of error flags and counter.
REQ-012 out_valid  output  1  packed word present.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_data  output  2*OUT_BASES  packed bases; first base in bits [2*OUT_BASES-1:2*OUT_BASES-2].
REQ-015 out_count  output  $clog2(OUT_BASES+1)  valid bases in out_data.
REQ-016 out_last  output  1  word closes a line.
REQ-017 err_invalid  output  1  sticky: non-ACGT character seen.
REQ-018 err_len  output  1  sticky: line length differed from LINE_LEN.
REQ-019 invalid_cnt  output  16  count of non-ACGT characters, saturating at 0xFFFF.

Function
REQ-020 Encoding SHALL be A/a=00, C/c=01, G/g=10, T/t=11; every other byte SHALL encode as 00 and is counted as invalid.
REQ-021 FSM states SHALL be FILL and EMIT; in_ready=1 only in FILL; out_valid=1 only in EMIT.
REQ-022 In FILL, an accepted beat (in_valid&in_ready) SHALL append its 2*CHARS_PER_BEAT bits below the previously packed bases.
REQ-023 FILL->EMIT SHALL occur on the accepted beat that makes the accumulator hold OUT_BASES bases, or on any accepted beat with in_last=1.
REQ-024 On in_last, only the first in_nchars bases SHALL be packed; in_nchars=0 SHALL be treated as CHARS_PER_BEAT.
REQ-025 Unused low bits of a partial word SHALL be 0; out_count SHALL equal the packed base count; out_last SHALL equal 1 only for the in_last-terminated word.
REQ-026 out_data, out_count and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027 EMIT->FILL SHALL occur on out_ready=1; the accumulator and out_count SHALL clear in that cycle.
REQ-028 Latency: out_valid SHALL rise one cycle after the completing beat is accepted.
REQ-029 A line-base counter SHALL track the bases of the current line and reset after in_last; err_len SHALL set if the total at in_last differs from LINE_LEN.
REQ-030 invalid_cnt SHALL add the number of invalid valid-position characters per accepted beat and saturate at 0xFFFF.
REQ-031 clr_err=1 SHALL zero err_invalid, err_len and invalid_cnt; events in the same cycle SHALL be discarded (clear wins).

Reset
REQ-032 rst_n=0 SHALL force FILL, in_ready=1 after release, out_valid=0, out_data=0, out_count=0, out_last=0, err_invalid=0, err_len=0, invalid_cnt=0, and line counter=0.
REQ-033 Reset mid-line or mid-EMIT SHALL discard the partial word without emitting it; the first beat after release SHALL start a new line.

Verification
REQ-034 Four accepted beats of "ACGT" -> one word 0x1B1B1B1B, out_count=16, out_last=0, no errors.
REQ-035 100-base line of 'T' (25 beats, in_last on the 25th) -> six words 0xFFFFFFFF with count 16, then 0xFF000000 with count 4 and out_last=1, err_len=0.
REQ-036 Beat "ANgT" -> bits 0x0B, err_invalid=1, invalid_cnt=1; then clr_err -> flags and counter 0.
REQ-037 Hold out_ready=0 for 5 cycles during EMIT -> out_data stable, in_ready=0, no beat consumed; out_ready=1 -> FILL on next cycle.
REQ-038 Line of 10 beats with in_last and in_nchars=2 (38 bases) -> last word count 6, out_last=1, err_len=1.
REQ-039 Assert rst_n=0 after 2 beats -> all outputs at reset values, no word emitted.
